// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, ALU
// operation codes, opcodes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    // Must match the ALU's operation decode bit-for-bit.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation for R- and I-type instructions,
// flagging encodings the ALU cannot execute.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct3)
            // For I-type, bit 30 belongs to the immediate, so addi stays ADD.
            3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111: alu_control = ALU_AND;
            3'b110: alu_control = ALU_OR;
            3'b101: begin
                if (funct7b5) illegal = 1'b1;
                else          alu_control = ALU_SRL;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable and select. dbg_state exposes the current state.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] dbg_state
);

    state_t     state_q, state_d;
    logic [3:0] dec_alu_control;
    logic       dec_illegal;
    logic       is_rtype, is_itype, legal_op, bad_encoding;

    assign is_rtype     = (opcode == OP_R);
    assign is_itype     = (opcode == OP_I);
    assign legal_op     = (opcode == OP_LW) || (opcode == OP_SW) || is_rtype ||
                          is_itype || (opcode == OP_BEQ);
    assign bad_encoding = !legal_op || ((is_rtype || is_itype) && dec_illegal);
    assign dbg_state    = state_q;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (is_rtype),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        if (opcode == OP_SW)       ImmSrc = IMM_S;
        else if (opcode == OP_BEQ) ImmSrc = IMM_B;
        else                       ImmSrc = IMM_I;
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_ADD;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (bad_encoding) begin
                    Illegal   = 1'b1;
                    InstrDone = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_rtype)        state_d = S_EXECUTER;
                else if (is_itype)            state_d = S_EXECUTEI;
                else if (opcode == OP_BEQ)    state_d = S_BEQ;
                else                          state_d = S_MEMADR;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = dec_alu_control;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu_control;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = Zero;
                InstrDone  = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every side effect so an abandoned instruction writes nothing.
        if (reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
            Illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its per-cycle control vectors, checked every cycle.
module tb_multicycle_control;

    localparam int W = 19;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    logic       InstrDone, Illegal;
    logic [3:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;
    int cyc;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level model: the full list of control vectors one instruction produces.
    function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                  input logic f7, input logic z,
                                  output ctrl_t seq[5], output int n);
        logic       is_r, is_i, bad_enc;
        logic [3:0] alu;
        ctrl_t      base;
        is_r    = (op == RT);
        is_i    = (op == IT);
        alu     = 4'b0000;
        bad_enc = !(op == LW || op == SW || is_r || is_i || op == BEQ);
        if (is_r || is_i) begin
            if (f3 == 3'b000)             alu = (is_r && f7) ? 4'b0001 : 4'b0000;
            else if (f3 == 3'b111)        alu = 4'b0010;
            else if (f3 == 3'b110)        alu = 4'b0011;
            else if (f3 == 3'b101 && !f7) alu = 4'b0101;
            else                          bad_enc = 1'b1;
        end
        base         = '0;
        base.imm_src = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : 2'b00;
        for (int k = 0; k < 5; k++) seq[k] = base;

        seq[0].pc_write   = 1'b1;
        seq[0].ir_write   = 1'b1;
        seq[0].alu_src_b  = 2'b10;
        seq[0].result_src = 2'b10;
        seq[1].alu_src_a  = 2'b01;
        seq[1].alu_src_b  = 2'b01;
        seq[2].alu_src_a  = 2'b10;

        if (bad_enc) begin
            n = 2;
            seq[1].instr_done = 1'b1;
            seq[1].illegal    = 1'b1;
        end else if (op == BEQ) begin
            n = 3;
            seq[2].alu_control = 4'b0001;
            seq[2].pc_write    = z;
            seq[2].instr_done  = 1'b1;
        end else if (is_r || is_i) begin
            n = 4;
            seq[2].alu_src_b   = is_i ? 2'b01 : 2'b00;
            seq[2].alu_control = alu;
            seq[3].reg_write   = 1'b1;
            seq[3].instr_done  = 1'b1;
        end else if (op == SW) begin
            n = 4;
            seq[2].alu_src_b  = 2'b01;
            seq[3].adr_src    = 1'b1;
            seq[3].mem_write  = 1'b1;
            seq[3].instr_done = 1'b1;
        end else begin
            n = 5;
            seq[2].alu_src_b  = 2'b01;
            seq[3].adr_src    = 1'b1;
            seq[4].result_src = 2'b01;
            seq[4].reg_write  = 1'b1;
            seq[4].instr_done = 1'b1;
        end
    endfunction

    function automatic ctrl_t under_reset(input ctrl_t v);
        ctrl_t r;
        r            = v;
        r.pc_write   = 1'b0;
        r.mem_write  = 1'b0;
        r.ir_write   = 1'b0;
        r.reg_write  = 1'b0;
        r.instr_done = 1'b0;
        r.illegal    = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: holds the fields for each cycle and queues that cycle's vector.
    // max_cyc = 0 runs the whole instruction; otherwise it is cut short.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int max_cyc);
        ctrl_t seq[5];
        int    n;
        build(op, f3, f7, z, seq, n);
        if (max_cyc != 0 && max_cyc < n) n = max_cyc;
        for (int k = 0; k < n; k++) begin
            opcode   = op;
            funct3   = f3;
            funct7b5 = f7;
            Zero     = (op == BEQ && k == 2) ? z : 1'($urandom_range(0, 1));
            exp_q.push_back(seq[k]);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset for two cycles: the interrupted state's vector, then FETCH, both muted.
    task automatic reset_during(input ctrl_t held, input ctrl_t fetch_v);
        reset = 1'b1;
        Zero  = 1'($urandom_range(0, 1));
        exp_q.push_back(under_reset(held));
        @(posedge clk);
        #1;
        exp_q.push_back(under_reset(fetch_v));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // scoreboard compare
    always @(negedge clk) begin
        ctrl_t exp_v, act_v;
        cyc++;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL ctrl_vec cyc=%0d: got %05h expected %05h (pcw/adr/mw/irw/rw/res/a/b/imm/alu/done/ill)",
                         cyc, act_v, exp_v);
            end
        end
    end

    initial begin
        ctrl_t seq[5];
        ctrl_t lw_seq[5];
        int    n;
        total = 0;
        bad   = 0;
        cyc   = 0;

        // Hand-computed pins on the model itself.
        build(RT, 3'b000, 1'b1, 1'b0, seq, n);
        check("model_sub_alu", int'(seq[2].alu_control), 1);
        check("model_r_len", n, 4);
        check("model_r_regwrite_c4", int'(seq[3].reg_write), 1);
        build(IT, 3'b101, 1'b0, 1'b0, seq, n);
        check("model_srli_alu", int'(seq[2].alu_control), 5);
        check("model_srli_srcb", int'(seq[2].alu_src_b), 1);
        build(IT, 3'b101, 1'b1, 1'b0, seq, n);
        check("model_srli_f7_len", n, 2);
        build(BEQ, 3'b000, 1'b0, 1'b1, seq, n);
        check("model_beq_pcw", int'(seq[2].pc_write), 1);
        check("model_beq_len", n, 3);
        build(LW, 3'b010, 1'b0, 1'b0, seq, n);
        check("model_lw_len", n, 5);
        check("model_lw_res", int'(seq[4].result_src), 1);
        build(SW, 3'b010, 1'b0, 1'b0, seq, n);
        check("model_sw_imm", int'(seq[3].imm_src), 1);
        check("model_sw_mw", int'(seq[3].mem_write), 1);
        build(7'b1111111, 3'b000, 1'b0, 1'b0, seq, n);
        check("model_bad_op_ill", int'(seq[1].illegal), 1);

        // Power-on reset; the second reset cycle already sits in FETCH.
        reset    = 1'b1;
        opcode   = 7'd0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        @(posedge clk);
        #1;
        build(7'd0, 3'd0, 1'b0, 1'b0, seq, n);
        exp_q.push_back(under_reset(seq[0]));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(RT, 3'b000, 1'b0, 1'b0, 0);           // add
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0);           // sub
        run_instr(RT, 3'b111, 1'b0, 1'b0, 0);           // and
        run_instr(RT, 3'b101, 1'b0, 1'b0, 0);           // srl
        run_instr(IT, 3'b110, 1'b0, 1'b0, 0);           // ori
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0);           // addi, imm bit 30 set
        run_instr(IT, 3'b101, 1'b0, 1'b0, 0);           // srli
        run_instr(IT, 3'b101, 1'b1, 1'b0, 0);           // srai: illegal
        run_instr(RT, 3'b010, 1'b0, 1'b0, 0);           // slt: illegal
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0);
        run_instr(BEQ, 3'b000, 1'b0, 1'b1, 0);
        run_instr(BEQ, 3'b000, 1'b0, 1'b0, 0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0);

        // lw interrupted by reset while in MEMREAD.
        build(LW, 3'b010, 1'b0, 1'b0, lw_seq, n);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 3);
        reset_during(lw_seq[3], lw_seq[0]);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0);
        run_instr(BEQ, 3'b000, 1'b0, 1'b1, 0);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the RISC-V core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It decodes opcode/funct fields and drives every datapath enable and mux select, including the 4-bit ALUControl code consumed by the ALU. It also uses the ALU's Zero flag to resolve beq. It sits between the instruction register and the shared datapath.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock; sole clock.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- ALUControl  out  4  ALU operation code: 0000 = ADD, 0001 = SUB, 0010 = AND, 0011 = OR, 0101 = SRL.
- InstrDone  out  1  one-cycle pulse in the last cycle of each instruction.
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding.

## Operation
Supported opcodes:
- lw = 0000011, sw = 0100011, R = 0110011, I = 0010011, beq = 1100011.

Funct decode (R and I types share it):
- funct3 000 → ADD. For R-type only, funct7b5 = 1 → SUB.
- funct3 111 → AND.
- funct3 110 → OR.
- funct3 101 with funct7b5 = 0 → SRL.
- Any other funct3/funct7b5 combination is illegal.

ImmSrc is decoded combinationally from opcode in every state:
- sw → 01, beq → 10, all other opcodes → 00.

Defaults in every state unless listed below: all enables 0, AdrSrc 0, selects 00, ALUControl ADD.

States and per-state outputs:
- FETCH: IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10. Next state: DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01 (computes the branch target into ALUOut).
  - lw/sw → MEMADR; R → EXECUTER; I → EXECUTEI; beq → BEQ.
  - Illegal opcode or funct → pulse Illegal and InstrDone, next state FETCH.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc = 1. Next state: MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, InstrDone = 1. Next state: FETCH.
- MEMWRITE: AdrSrc = 1, MemWrite = 1, InstrDone = 1. Next state: FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUControl = funct decode. Next state: ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUControl = funct decode. Next state: ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, InstrDone = 1. Next state: FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUControl = SUB, ResultSrc = 00, PCWrite = Zero (Mealy), InstrDone = 1. Next state: FETCH.

## Timing
- State register updates on the rising edge of clk. All outputs are combinational from the current state and fields; only BEQ PCWrite also depends on Zero.
- Cycles per instruction, including FETCH: beq 3, R/I 4, sw 4, lw 5, illegal 2.
- Reset:
  - While reset is high, all enables (PCWrite, MemWrite, IRWrite, RegWrite) are forced to 0 and InstrDone/Illegal are forced to 0.
  - The next state is FETCH.
  - Reset asserted mid-instruction abandons the instruction with no further write; the first cycle after reset deasserts is FETCH.
- opcode and funct fields are only sampled from DECODE onward; they are stable because IRWrite is 1 only in FETCH.
- Zero is sampled combinationally in BEQ only; Zero in other states has no effect.
- No stall or handshake input: memory is single-cycle.

## Structure
- Package riscv_ctrl_pkg holds:
  - state enum.
  - ALUControl codes (ADD, SUB, AND, OR, SRL).
  - opcode constants.
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- The ALU package/encodings must match the ALU exactly (0000/0001/0010/0011/0101).
- One sub-module, alu_decoder: combinational mapping of funct3, funct7b5 and an is_rtype flag to ALUControl plus an illegal flag. The FSM instantiates it once.

## Test plan
- Reset held 2 cycles mid-lw (in MEMREAD) → no RegWrite; FETCH next cycle with IRWrite = 1 and PCWrite = 1.
- add then sub (opcode 0110011, funct3 000, funct7b5 0 then 1):
  - ALUControl 0000 then 0001 in EXECUTER.
  - RegWrite in cycle 4.
  - InstrDone every 4 cycles.
- srli (0010011, funct3 101, funct7b5 0) → ALUControl 0101, ALUSrcB 01. With funct7b5 1 → Illegal pulse in cycle 2, then back to FETCH.
- lw → states FETCH → DECODE → MEMADR → MEMREAD → MEMWB, with ResultSrc 01 and RegWrite in cycle 5. sw → MemWrite in cycle 4, ImmSrc 01, no RegWrite.
- beq with Zero = 1 → PCWrite = 1 in cycle 3 with ALUControl 0001. With Zero = 0 → PCWrite stays 0 and the next cycle is FETCH.
- Unsupported opcode 1111111 → Illegal and InstrDone pulse in DECODE; no enables asserted apart from FETCH's.
